tlb_refill_ctrl: RTL and testbench
==================================

# tlb_refill_ctrl

Refill controller sitting between the two tcache instances (fetch-side and data-side) and the main TLB. On a tcache miss it arbitrates between requesters, sequences a search and an entry read of the main TLB, then drives the winning tcache's refill port and reports hit/miss back to the requesting pipeline stage. A miss reported here is the TLB-refill exception condition.

## Interface
- `TLB_IDX_W`, 4: main-TLB index width; `refill_index` carries it.
- `N_REQ`, fixed 2: requesters, 0 = fetch, 1 = data. Not overridable.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid[N_REQ]` in 1: tcache miss pending. Held until `resp_valid` for that port.
- `req_vppn[N_REQ]` in 19, `req_va_bit12[N_REQ]` in 1, `req_asid[N_REQ]` in 10: miss address, stable while `req_valid`.
- `resp_valid[N_REQ]` out 1: one-cycle completion pulse.
- `resp_found[N_REQ]` out 1: qualifies `resp_valid`; 0 = main TLB miss.
- `refill_valid[N_REQ]` out 1: to the tcache refill port.
- `refill_data[N_REQ]` out tlb_entry_t: to the tcache refill port.
- `refill_index[N_REQ]` out TLB_IDX_W: to the tcache refill port.
- `ms_valid` out 1: main-TLB search strobe.
- `ms_vppn` out 19, `ms_va_bit12` out 1, `ms_asid` out 10: main-TLB search key.
- `ms_found` in 1, `ms_index` in TLB_IDX_W: search result, registered, valid the cycle after `ms_valid`.
- `mr_index` out TLB_IDX_W: main-TLB read index.
- `mr_entry` in tlb_entry_t: read data, registered, valid the cycle after `mr_index` is driven in READ.
- `invtlb_valid` in 1, `tlb_we` in 1: TLB contents changing (INVTLB / TLBWR / TLBFILL).

## Operation
- States: IDLE, SEARCH, READ, REFILL.
- IDLE: if any `req_valid`, the round-robin arbiter grants one requester and captures its vppn/asid/bit12 and its id → SEARCH.
- SEARCH: drive `ms_valid` = 1 with the captured key → READ.
- READ: sample `ms_found` and `ms_index`.
  - `ms_found` = 0: pulse `resp_valid` = 1, `resp_found` = 0 to the granted port → IDLE. No refill.
  - `ms_found` = 1: drive `mr_index` = `ms_index` and latch the index → REFILL.
- REFILL: pulse `refill_valid` with `refill_data` = `mr_entry` and `refill_index` = latched index. In the same cycle pulse `resp_valid` = 1, `resp_found` = 1 → IDLE.
- Round-robin: a 1-bit pointer names the preferred requester. After each completed response, the pointer moves to the other requester. With a single requester it always wins.
- Abort: `invtlb_valid` or `tlb_we` in SEARCH, READ or REFILL → IDLE without asserting `refill_valid` or `resp_valid`.
  - The request stays pending and is re-arbitrated; the pointer does not move.
  - An abort in REFILL takes priority: the refill pulse is suppressed.
- Dropping `req_valid` before response is illegal (assertion). A request deasserted while IDLE is simply not granted.
- Outputs to the non-granted port stay 0.

## Timing
- Reset: state IDLE, pointer = 0 (fetch preferred), all `resp_*`, `refill_valid`, `ms_valid` = 0. `refill_data`, `refill_index`, `mr_index`, `ms_*` data fields = 0.
- `reset` mid-walk: IDLE next cycle, no response issued.
- Hit latency: `req_valid` seen in IDLE at cycle 0 → SEARCH at 1 → READ at 2 → `refill_valid` / `resp_valid` at 3.
- Miss latency: `resp_valid` at cycle 2.
- Back-to-back: the next grant is made in the IDLE cycle following the response. Throughput is one walk per 4 cycles (hit) or 3 cycles (miss).

## Configuration
- `TLB_REFILL_MERGE_EN` defined:
  - At grant, the other requester's key is compared with the granted key: same vppn, same asid, and `req_va_bit12` equal when ps is 4KB.
  - On a match, both ports are marked granted and receive `refill_valid` / `resp_valid` in the same cycle.
  - The pointer advances once.
- `TLB_REFILL_MERGE_EN` undefined: no comparison; requests are strictly serialized.

## Structure
- Shared package `definitions.svh`: `tlb_entry_t` (existing), plus new `refill_state_t` enum (IDLE, SEARCH, READ, REFILL).
- Sub-module `rr_arb2`: two-way round-robin arbiter. Inputs are req[1:0] and advance; outputs are a one-hot grant and the pointer.

## Test plan
- Fetch miss, vppn 0x12345, main TLB hit at index 7 → `refill_valid[0]` at cycle 3 with `refill_index` = 7 and `refill_data` = entry 7; `resp_found[0]` = 1.
- Data miss, `ms_found` = 0 → `resp_valid[1]` = 1 with `resp_found[1]` = 0 at cycle 2; no `refill_valid`.
- Both ports request continuously with different vppn → grants alternate 0,1,0,1; each response is 4 cycles apart.
- `invtlb_valid` pulsed in READ → no response; the walk restarts and completes at cycle 3 after the following IDLE.
- `reset` asserted in REFILL → `refill_valid` stays 0 and state returns to IDLE.
- MERGE_EN: both ports miss on vppn 0x00400 with asid 5 → a single walk; `refill_valid[0]` and `refill_valid[1]` assert in the same cycle.

Source files
------------

// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared types for the TLB refill controller: main-TLB entry layout and walk states.
package tlb_refill_ctrl_pkg;

  localparam int N_REQ = 2;
  localparam logic [5:0] PS_4KB = 6'd12;

  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic        e;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [1:0] {IDLE, SEARCH, READ, REFILL} refill_state_t;

endpackage

// File: rtl/tlb_refill_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the preferred requester and
// toggles on every advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic [1:0] pref;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  always_comb begin
    pref  = ptr ? 2'b10 : 2'b01;
    grant = ((req & pref) != 2'b00) ? pref : (req & ~pref);
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// Refill walker between the fetch/data tcaches and the main TLB; a reported miss is the
// TLB-refill exception. Define TLB_REFILL_MERGE_EN to serve identical misses with one walk.
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
#(
  parameter int TLB_IDX_W = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][18:0]              req_vppn,
  input  logic [N_REQ-1:0]                    req_va_bit12,
  input  logic [N_REQ-1:0][9:0]               req_asid,
  output logic [N_REQ-1:0]                    resp_valid,
  output logic [N_REQ-1:0]                    resp_found,
  output logic [N_REQ-1:0]                    refill_valid,
  output tlb_entry_t [N_REQ-1:0]              refill_data,
  output logic [N_REQ-1:0][TLB_IDX_W-1:0]     refill_index,
  output logic                                ms_valid,
  output logic [18:0]                         ms_vppn,
  output logic                                ms_va_bit12,
  output logic [9:0]                          ms_asid,
  input  logic                                ms_found,
  input  logic [TLB_IDX_W-1:0]                ms_index,
  output logic [TLB_IDX_W-1:0]                mr_index,
  input  tlb_entry_t                          mr_entry,
  input  logic                                invtlb_valid,
  input  logic                                tlb_we
);

  // IDLE: arbitrate | SEARCH: key to main TLB | READ: search result | REFILL: write tcache
  refill_state_t state, state_nx;

  logic [1:0]           arb_grant;
  logic                 arb_ptr;
  logic                 advance;
  logic                 load;
  logic                 idx_load;
  logic                 abort;
  logic                 gnt_id;
  logic [1:0]           grant_mask;
  logic [1:0]           gnt_mask;
  logic [1:0]           refill_mask;
  logic [TLB_IDX_W-1:0] lat_idx;
  logic [18:0]          key_vppn;
  logic [9:0]           key_asid;
  logic                 key_bit12;
`ifdef TLB_REFILL_MERGE_EN
  logic [1:0]           prim_mask;
`endif

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .grant   (arb_grant),
    .ptr     (arb_ptr)
  );

  assign abort       = invtlb_valid | tlb_we;
  assign ms_vppn     = key_vppn;
  assign ms_asid     = key_asid;
  assign ms_va_bit12 = key_bit12;

  always_comb begin
    gnt_id     = arb_grant[1];
    grant_mask = arb_grant;
`ifdef TLB_REFILL_MERGE_EN
    if ((&req_valid) && (req_vppn[0] == req_vppn[1]) && (req_asid[0] == req_asid[1]))
      grant_mask = 2'b11;
`endif
  end

  // Page size is only known once the entry is read, so a merged partner whose
  // bit12 disagrees on a 4KB page falls back to its own walk.
  always_comb begin
    refill_mask = gnt_mask;
`ifdef TLB_REFILL_MERGE_EN
    if ((gnt_mask == 2'b11) && (mr_entry.ps == PS_4KB) &&
        (req_va_bit12[0] != req_va_bit12[1]))
      refill_mask = prim_mask;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt_mask  <= 2'b00;
      lat_idx   <= '0;
      key_vppn  <= '0;
      key_asid  <= '0;
      key_bit12 <= 1'b0;
`ifdef TLB_REFILL_MERGE_EN
      prim_mask <= 2'b00;
`endif
    end else begin
      state <= state_nx;
      if (load) begin
        gnt_mask  <= grant_mask;
        key_vppn  <= req_vppn[gnt_id];
        key_asid  <= req_asid[gnt_id];
        key_bit12 <= req_va_bit12[gnt_id];
`ifdef TLB_REFILL_MERGE_EN
        prim_mask <= arb_grant;
`endif
      end
      if (idx_load) begin
        lat_idx <= ms_index;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    load         = 1'b0;
    idx_load     = 1'b0;
    advance      = 1'b0;
    ms_valid     = 1'b0;
    mr_index     = '0;
    resp_valid   = '0;
    resp_found   = '0;
    refill_valid = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          load     = 1'b1;
          state_nx = SEARCH;
        end
      end
      SEARCH: begin
        ms_valid = 1'b1;
        state_nx = abort ? IDLE : READ;
      end
      READ: begin
        mr_index = ms_index;
        if (abort) begin
          state_nx = IDLE;
        end else if (ms_found) begin
          idx_load = 1'b1;
          state_nx = REFILL;
        end else begin
          resp_valid = gnt_mask;
          advance    = 1'b1;
          state_nx   = IDLE;
        end
      end
      REFILL: begin
        state_nx = IDLE;
        if (!abort) begin
          refill_valid = refill_mask;
          resp_valid   = refill_mask;
          resp_found   = refill_mask;
          advance      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A reset landing mid-walk must not leak a response or refill pulse.
    if (reset) begin
      ms_valid     = 1'b0;
      resp_valid   = '0;
      resp_found   = '0;
      refill_valid = '0;
      advance      = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      refill_data[i]  = refill_valid[i] ? mr_entry : '0;
      refill_index[i] = refill_valid[i] ? lat_idx : '0;
    end
  end

  req_held: assert property (@(posedge clk) disable iff (reset)
    (state != IDLE) |-> ((req_valid & gnt_mask) == gnt_mask));

  rr_fair: assert property (@(posedge clk) disable iff (reset)
    ((state == IDLE) && (&req_valid)) |-> arb_grant[arb_ptr]);

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Bench for tlb_refill_ctrl: a behavioural main TLB answers searches/reads, and a
// transaction-level schedule predicts every cycle's outputs for each request set.
module tb_tlb_refill_ctrl;

  localparam int IW    = 4;
  localparam int K_INV = 0;
  localparam int K_WE  = 1;
  localparam int K_RST = 2;

  typedef tlb_refill_ctrl_pkg::tlb_entry_t entry_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0][18:0] req_vppn = '0;
  logic [1:0]       req_va_bit12 = '0;
  logic [1:0][9:0]  req_asid = '0;
  logic [1:0]       resp_valid, resp_found, refill_valid;
  entry_t [1:0]     refill_data;
  logic [1:0][IW-1:0] refill_index;
  logic             ms_valid;
  logic [18:0]      ms_vppn;
  logic             ms_va_bit12;
  logic [9:0]       ms_asid;
  logic             ms_found;
  logic [IW-1:0]    ms_index;
  logic [IW-1:0]    mr_index;
  entry_t           mr_entry;
  logic             invtlb_valid = 1'b0;
  logic             tlb_we = 1'b0;

  int passed = 0;
  int total  = 0;
  bit mptr   = 1'b0;

  entry_t tlb [16];

  logic [1:0]    ev_resp  [64];
  logic [1:0]    ev_found [64];
  logic [1:0]    ev_refv  [64];
  logic          ev_ms    [64];
  logic [18:0]   ev_msv   [64];
  logic [IW-1:0] ev_idx   [64];
  entry_t        ev_data  [64];
  logic [1:0]    ev_drop  [64];
  logic          ev_inv   [64];
  logic          ev_we    [64];
  logic          ev_rst   [64];

  always #5 clk = ~clk;

  tlb_refill_ctrl #(.TLB_IDX_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_vppn     (req_vppn),
    .req_va_bit12 (req_va_bit12),
    .req_asid     (req_asid),
    .resp_valid   (resp_valid),
    .resp_found   (resp_found),
    .refill_valid (refill_valid),
    .refill_data  (refill_data),
    .refill_index (refill_index),
    .ms_valid     (ms_valid),
    .ms_vppn      (ms_vppn),
    .ms_va_bit12  (ms_va_bit12),
    .ms_asid      (ms_asid),
    .ms_found     (ms_found),
    .ms_index     (ms_index),
    .mr_index     (mr_index),
    .mr_entry     (mr_entry),
    .invtlb_valid (invtlb_valid),
    .tlb_we       (tlb_we)
  );

  function automatic int lookup(input logic [18:0] vppn, input logic [9:0] asid);
    for (int i = 0; i < 16; i++)
      if (tlb[i].e && (tlb[i].vppn == vppn) && (tlb[i].g || (tlb[i].asid == asid)))
        return i;
    return -1;
  endfunction

  function automatic entry_t rand_entry(input int i);
    logic [95:0] r;
    entry_t e;
    r = {$urandom(), $urandom(), $urandom()};
    e = r[$bits(entry_t)-1:0];
    e.vppn = {3'b111, 12'($urandom()), 4'(i)};
    e.ps   = ($urandom_range(1) == 0) ? tlb_refill_ctrl_pkg::PS_4KB : 6'd21;
    e.e    = ($urandom_range(7) != 0);
    e.g    = ($urandom_range(3) == 0);
    return e;
  endfunction

  // Main TLB: registered search result and registered entry read.
  always @(posedge clk) begin : main_tlb
    int h;
    h = lookup(ms_vppn, ms_asid);
    ms_found <= ms_valid && (h >= 0);
    ms_index <= (h >= 0) ? h[IW-1:0] : 4'($urandom_range(15));
    mr_entry <= tlb[mr_index];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Predicts the whole episode for a request set, then drives and checks it cycle by cycle.
  task automatic run_case(input logic [1:0] mask, input int ab_walk, input int ab_k,
                          input int ab_kind);
    logic [1:0] pend, served, rmask;
    int t, w, h, lat, k, walk;
    for (int c = 0; c < 64; c++) begin
      ev_resp[c] = '0; ev_found[c] = '0; ev_refv[c] = '0; ev_ms[c] = 1'b0;
      ev_msv[c] = '0; ev_idx[c] = '0; ev_data[c] = '0; ev_drop[c] = '0;
      ev_inv[c] = 1'b0; ev_we[c] = 1'b0; ev_rst[c] = 1'b0;
    end
    pend = mask;
    t = 0;
    walk = 0;
    while (pend != 2'b00) begin
      w = pend[mptr] ? int'(mptr) : int'(!mptr);
      served = 2'b01 << w;
`ifdef TLB_REFILL_MERGE_EN
      if ((pend == 2'b11) && (req_vppn[0] == req_vppn[1]) && (req_asid[0] == req_asid[1]))
        served = 2'b11;
`endif
      h = lookup(req_vppn[w], req_asid[w]);
      lat = (h >= 0) ? 3 : 2;
      ev_ms[t+1]  = 1'b1;
      ev_msv[t+1] = req_vppn[w];
      if (walk == ab_walk) begin
        k = (ab_k > lat) ? lat : ab_k;
        case (ab_kind)
          K_INV:   ev_inv[t+k] = 1'b1;
          K_WE:    ev_we[t+k]  = 1'b1;
          default: begin
            ev_rst[t+k] = 1'b1;
            mptr = 1'b0;
            if (k == 1) ev_ms[t+1] = 1'b0;
          end
        endcase
        t += k + 1;
      end else begin
        rmask = served;
        if ((h >= 0) && (served == 2'b11) && (tlb[h].ps == tlb_refill_ctrl_pkg::PS_4KB) &&
            (req_va_bit12[0] != req_va_bit12[1]))
          rmask = 2'b01 << w;
        ev_resp[t+lat] = (h >= 0) ? rmask : served;
        if (h >= 0) begin
          ev_found[t+lat] = rmask;
          ev_refv[t+lat]  = rmask;
          ev_idx[t+lat]   = 4'(h);
          ev_data[t+lat]  = tlb[h];
        end
        ev_drop[t+lat+1] = ev_resp[t+lat];
        pend &= ~ev_resp[t+lat];
        mptr = !mptr;
        t += lat + 1;
      end
      walk++;
    end
    for (int c = 0; c <= t; c++) begin
      if (c == 0) req_valid = mask;
      req_valid    = req_valid & ~ev_drop[c];
      invtlb_valid = ev_inv[c];
      tlb_we       = ev_we[c];
      reset        = ev_rst[c];
      @(negedge clk);
      chk("resp_valid", resp_valid, ev_resp[c]);
      chk("resp_found", resp_found, ev_found[c]);
      chk("refill_valid", refill_valid, ev_refv[c]);
      chk("ms_valid", ms_valid, ev_ms[c]);
      if (ev_ms[c]) chk("ms_vppn", ms_vppn, ev_msv[c]);
      for (int p = 0; p < 2; p++) begin
        if (ev_refv[c][p]) begin
          chk("refill_index", refill_index[p], ev_idx[c]);
          chk("refill_data", refill_data[p], ev_data[c]);
        end
      end
      @(posedge clk);
      #1;
    end
    invtlb_valid = 1'b0;
    tlb_we       = 1'b0;
    reset        = 1'b0;
  endtask

  initial begin : stim
    int idx;
    logic [1:0] m;
    for (int i = 0; i < 16; i++) tlb[i] = rand_entry(i);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_resp_found", resp_found, 2'b00);
    chk("rst_refill_valid", refill_valid, 2'b00);
    chk("rst_ms_valid", ms_valid, 1'b0);
    chk("rst_ms_key", {ms_vppn, ms_asid, ms_va_bit12}, 30'h0);
    chk("rst_mr_index", mr_index, 4'h0);
    chk("rst_refill_index", refill_index, 8'h00);
    chk("rst_refill_data", refill_data[0] | refill_data[1], 89'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fetch miss on 0x12345, main TLB hit at index 7.
    tlb[7].vppn = 19'h12345; tlb[7].e = 1'b1; tlb[7].g = 1'b1;
    req_vppn[0] = 19'h12345; req_asid[0] = 10'h0;
    run_case(2'b01, -1, 1, K_INV);
    // Data miss, not present in the main TLB.
    req_vppn[1] = 19'h60000; req_asid[1] = 10'h3;
    run_case(2'b10, -1, 1, K_INV);
    // Both ports, different hits: alternating grants.
    tlb[2].e = 1'b1; tlb[2].g = 1'b1;
    req_vppn[1] = tlb[2].vppn;
    run_case(2'b11, -1, 1, K_INV);
    run_case(2'b11, -1, 1, K_INV);
    // Aborts: invtlb in READ, tlb_we in SEARCH, invtlb in REFILL, reset in REFILL.
    run_case(2'b01, 0, 2, K_INV);
    run_case(2'b11, 0, 1, K_WE);
    run_case(2'b10, 0, 3, K_INV);
    run_case(2'b01, 0, 3, K_RST);
    run_case(2'b11, 1, 2, K_RST);
    // Identical misses on 0x00400 / asid 5.
    tlb[3].vppn = 19'h00400; tlb[3].asid = 10'd5; tlb[3].g = 1'b0; tlb[3].e = 1'b1;
    req_vppn[0] = 19'h00400; req_vppn[1] = 19'h00400;
    req_asid[0] = 10'd5;     req_asid[1] = 10'd5;
    req_va_bit12 = 2'b00;
    run_case(2'b11, -1, 1, K_INV);

    for (int n = 0; n < 150; n++) begin
      if ((n % 25) == 0)
        for (int i = 0; i < 16; i++) tlb[i] = rand_entry(i);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(1) == 1) begin
          idx = $urandom_range(15);
          req_vppn[p] = tlb[idx].vppn;
          req_asid[p] = tlb[idx].g ? 10'($urandom()) : tlb[idx].asid;
        end else begin
          req_vppn[p] = {3'b110, 16'($urandom())};
          req_asid[p] = 10'($urandom());
        end
        req_va_bit12[p] = 1'($urandom());
      end
      if (req_vppn[1] == req_vppn[0]) req_vppn[1][0] = ~req_vppn[1][0];
      m = 2'($urandom_range(3, 1));
      if ($urandom_range(2) == 0)
        run_case(m, $urandom_range(1), $urandom_range(3, 1), $urandom_range(2));
      else
        run_case(m, -1, 1, K_INV);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
